hnf_l3_rd_return: RTL and testbench
===================================

Name: hnf_l3_rd_return

Overview:
Read-return stage directly downstream of the HN-F L3 data SRAM.
- Tracks every data-SRAM read issued by the cache pipeline through a fixed-latency shadow pipeline.
- Captures the SRAM's registered read data with its request ID into a small FIFO, then hands it to the data buffer under valid/ready.
- Exports a credit-based ready to the cache pipeline, so no returned line can ever be dropped.

Parameters:
DATA_WIDTH, 512, cache line width; equals the SRAM read data width.
ID_WIDTH, 8, request/buffer ID width carried with each read.
RD_LATENCY, 2, cycles from read issue (ways presented to SRAM) to valid read data at the SRAM output register; legal range 1..4.
FIFO_DEPTH, 4, return FIFO entries; power of two, minimum 2.

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-low reset
rd_issue_valid  in  1  pipeline drives a data-SRAM read this cycle (nonzero read ways)
rd_issue_id  in  ID_WIDTH  ID of that read
rd_issue_ready  out  1  a credit is available; pipeline issues only when high
l3_rd_data_q  in  DATA_WIDTH  registered read data from the data SRAM
out_valid  out  1  head FIFO entry valid
out_ready  in  1  data buffer accepts the head entry
out_id  out  ID_WIDTH  head entry ID
out_data  out  DATA_WIDTH  head entry data
fifo_count  out  clog2(FIFO_DEPTH+1)  current FIFO occupancy
issue_err  out  1  sticky: issue attempted with no credit

Behaviour:
Reset (rst low, asynchronous):
- Credits = FIFO_DEPTH; rd_issue_ready = 1.
- Shadow pipeline valids = 0; FIFO pointers and fifo_count = 0.
- out_valid = 0; out_id = 0; out_data = 0; issue_err = 0.
- Reset mid-operation discards in-flight reads and FIFO contents. Data arriving after reset release for pre-reset reads is ignored, because the shadow valids were cleared.

Issue and credit:
- issue = rd_issue_valid & rd_issue_ready.
- rd_issue_ready = (credits != 0), where credits is a registered count.
- Update each cycle: credits_nxt = credits - issue + pop, with pop = out_valid & out_ready.
- Invariant: credits + in-flight + fifo_count == FIFO_DEPTH.
- A pop frees its credit in the next cycle. There is no same-cycle bypass from pop to ready.
- rd_issue_valid & !rd_issue_ready: the request is ignored (no shadow entry, no credit change) and issue_err is set. issue_err clears only on reset.

Shadow pipeline:
- RD_LATENCY stages of {valid, id}.
- Stage 0 loads {issue, rd_issue_id} at the posedge of the issue cycle; each subsequent posedge shifts one stage.
- When the final stage is valid, l3_rd_data_q is the matching line. Push {id, l3_rd_data_q} into the FIFO in that cycle.
- Read issued in cycle N: FIFO write at the posedge ending cycle N+RD_LATENCY; out_valid visible in cycle N+RD_LATENCY+1 if the FIFO was empty.
- Back-to-back issues every cycle are supported and are returned in order.

FIFO:
- First-word-fall-through: out_valid = (fifo_count != 0); out_id and out_data show the head entry combinationally from storage.
- Outputs are held stable while out_valid & !out_ready.
- Read and write pointers are clog2(FIFO_DEPTH) bits and wrap naturally.
- Simultaneous push and pop: both occur, count unchanged. This is legal when full, and when empty is impossible (pop requires count != 0).
- Push while full cannot occur, because credits guarantee space. Add an assertion: push & (fifo_count == FIFO_DEPTH) never true.
- out_valid, out_id and out_data are don't-care when empty, but must read 0 after reset.

Arithmetic:
- credits and fifo_count are unsigned, clog2(FIFO_DEPTH+1) bits.
- credits never underflows (issue requires credits != 0) and never exceeds FIFO_DEPTH.

Test Plan:
- Reset check: after reset release, rd_issue_ready=1, out_valid=0, fifo_count=0, issue_err=0. Assert rst low mid-burst -> all return to these values asynchronously, and no stale push occurs afterwards.
- Single read latency: RD_LATENCY=2, issue id=0x05 at cycle 10, drive l3_rd_data_q=0xA5.. at cycle 12 -> out_valid high at cycle 13 with out_id=0x05 and out_data=0xA5.., out_ready=1 -> fifo_count back to 0 at cycle 14.
- Credit exhaustion: out_ready=0, issue ids 1,2,3,4 in consecutive cycles -> rd_issue_ready low from the cycle after the 4th issue, fifo_count reaches 4, entries popped in order 1,2,3,4.
- Illegal issue: with credits=0, assert rd_issue_valid id=0x7 -> issue_err=1 and stays set; FIFO contents and credits unchanged; id 0x7 never appears at out_id.
- Full-throughput streaming: out_ready=1 with continuous issue, ids 0..15 -> one pop per cycle after the initial latency, output order 0..15, credit stall only during initial fill if at all, no push-while-full assertion fire.
- Backpressure stability: out_ready toggling 1,0,0,1 with 3 entries queued -> out_id and out_data unchanged while out_ready=0; simultaneous push and pop when full keeps fifo_count=4.

Source files
------------

// File: rtl/hnf_l3_rd_return_if.sv
// hnf_l3_rd_return_if
//   Bundles the handshake and data signals of the HN-F L3 read-return stage.
//   master : the environment side (cache pipeline, SRAM data, data buffer).
//   slave  : the read-return stage itself.
//
//   rd_issue_valid / rd_issue_id / rd_issue_ready : read issue with credit ready
//   l3_rd_data_q                                  : registered SRAM read data
//   out_valid / out_ready / out_id / out_data     : return stream to data buffer
//   fifo_count                                    : return FIFO occupancy
//   issue_err                                     : sticky issue-without-credit
interface hnf_l3_rd_return_if #(
  parameter int DATA_WIDTH = 512,
  parameter int ID_WIDTH   = 8,
  parameter int FIFO_DEPTH = 4
);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  logic                  rd_issue_valid;
  logic [ID_WIDTH-1:0]   rd_issue_id;
  logic                  rd_issue_ready;
  logic [DATA_WIDTH-1:0] l3_rd_data_q;
  logic                  out_valid;
  logic                  out_ready;
  logic [ID_WIDTH-1:0]   out_id;
  logic [DATA_WIDTH-1:0] out_data;
  logic [CNT_W-1:0]      fifo_count;
  logic                  issue_err;

  modport master (
    output rd_issue_valid, rd_issue_id, l3_rd_data_q, out_ready,
    input  rd_issue_ready, out_valid, out_id, out_data, fifo_count, issue_err
  );

  modport slave (
    input  rd_issue_valid, rd_issue_id, l3_rd_data_q, out_ready,
    output rd_issue_ready, out_valid, out_id, out_data, fifo_count, issue_err
  );
endinterface

// File: rtl/hnf_l3_rd_return.sv
// hnf_l3_rd_return
//   Read-return stage behind the HN-F L3 data SRAM. Every read issued by the
//   cache pipeline is tracked through a fixed-latency shadow pipeline; when the
//   tracked read reaches the SRAM output register its data is captured with the
//   request ID into a small first-word-fall-through FIFO and handed to the data
//   buffer under valid/ready. Issue is gated by a credit count so a returned
//   line always has a FIFO slot waiting for it.
//
//   clk  : clock
//   rst  : asynchronous active-low reset
//   bus  : hnf_l3_rd_return_if slave modport (issue, SRAM data, return stream,
//          fifo_count, issue_err)
module hnf_l3_rd_return #(
  parameter int DATA_WIDTH = 512,
  parameter int ID_WIDTH   = 8,
  parameter int RD_LATENCY = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  hnf_l3_rd_return_if.slave  bus
);

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int PTR_W = $clog2(FIFO_DEPTH);

  logic [CNT_W-1:0]      credits_q;
  logic [CNT_W-1:0]      fifo_count_q;
  logic                  rd_ready;
  logic                  issue;
  logic                  pop;
  logic                  push;
  logic                  out_valid;
  logic                  issue_err_q;

  logic [RD_LATENCY-1:0] sh_vld_q;
  logic [ID_WIDTH-1:0]   sh_id_q [RD_LATENCY];

  logic [PTR_W-1:0]      wr_ptr_q;
  logic [PTR_W-1:0]      rd_ptr_q;
  logic [ID_WIDTH-1:0]   mem_id   [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] mem_data [FIFO_DEPTH];

  // Ready comes only from the registered credit count; a pop returns its
  // credit one cycle later, never combinationally.
  assign rd_ready  = (credits_q != '0);
  assign issue     = bus.rd_issue_valid & rd_ready;
  assign out_valid = (fifo_count_q != '0);
  assign pop       = out_valid & bus.out_ready;
  assign push      = sh_vld_q[RD_LATENCY-1];

  // credits + in-flight + fifo_count is always FIFO_DEPTH
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      credits_q <= CNT_W'(FIFO_DEPTH);
    end else begin
      credits_q <= credits_q - CNT_W'(issue) + CNT_W'(pop);
    end
  end

  // Shadow of the SRAM read pipeline; clearing the valids on reset is what
  // discards data returning for reads issued before reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sh_vld_q <= '0;
      for (int i = 0; i < RD_LATENCY; i++) begin
        sh_id_q[i] <= '0;
      end
    end else begin
      sh_vld_q[0] <= issue;
      sh_id_q[0]  <= bus.rd_issue_id;
      for (int i = 1; i < RD_LATENCY; i++) begin
        sh_vld_q[i] <= sh_vld_q[i-1];
        sh_id_q[i]  <= sh_id_q[i-1];
      end
    end
  end

  // Storage needs no reset: the head is only visible while out_valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_id[wr_ptr_q]   <= sh_id_q[RD_LATENCY-1];
      mem_data[wr_ptr_q] <= bus.l3_rd_data_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      fifo_count_q <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      fifo_count_q <= fifo_count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      issue_err_q <= 1'b0;
    end else if (bus.rd_issue_valid & ~rd_ready) begin
      issue_err_q <= 1'b1;
    end
  end

  // Head is gated by out_valid so the outputs read zero after reset without
  // having to reset the line storage.
  assign bus.rd_issue_ready = rd_ready;
  assign bus.out_valid      = out_valid;
  assign bus.out_id         = out_valid ? mem_id[rd_ptr_q]   : '0;
  assign bus.out_data       = out_valid ? mem_data[rd_ptr_q] : '0;
  assign bus.fifo_count     = fifo_count_q;
  assign bus.issue_err      = issue_err_q;

  // Credits reserve a slot for every in-flight read, so a push never meets a
  // full FIFO.
  a_no_push_when_full: assert property (@(posedge clk) disable iff (!rst)
    !(push && (fifo_count_q == CNT_W'(FIFO_DEPTH))));

  a_credit_bound: assert property (@(posedge clk) disable iff (!rst)
    credits_q <= CNT_W'(FIFO_DEPTH));

endmodule

// File: tb/tb_hnf_l3_rd_return.sv
module tb_hnf_l3_rd_return;
  localparam int DW    = 512;
  localparam int IW    = 8;
  localparam int LAT   = 2;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  hnf_l3_rd_return_if #(.DATA_WIDTH(DW), .ID_WIDTH(IW), .FIFO_DEPTH(DEPTH)) bus ();

  hnf_l3_rd_return #(
    .DATA_WIDTH(DW), .ID_WIDTH(IW), .RD_LATENCY(LAT), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endfunction

  function automatic void chkd(string name, logic [DW-1:0] act, logic [DW-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endfunction

  function automatic logic [DW-1:0] rl();
    logic [DW-1:0] r;
    for (int i = 0; i < DW / 32; i++) r[i*32 +: 32] = $urandom();
    return r;
  endfunction

  // Reference model: reads in flight with the cycle their data is due, and
  // the returned lines waiting for the data buffer.
  typedef struct { logic [IW-1:0] id; int due; } infl_t;
  typedef struct { logic [IW-1:0] id; logic [DW-1:0] data; } ent_t;
  infl_t infl_q[$];
  ent_t  fifo_q[$];
  bit    m_err;
  int    cyc;
  logic [IW-1:0] popped_q[$];

  function automatic int m_credits();
    return DEPTH - infl_q.size() - fifo_q.size();
  endfunction

  function automatic void model_reset();
    infl_q.delete();
    fifo_q.delete();
    m_err = 1'b0;
    cyc   = 0;
  endfunction

  function automatic void model_check();
    chk("ready", 64'(bus.rd_issue_ready), 64'(m_credits() != 0));
    chk("out_valid", 64'(bus.out_valid), 64'(fifo_q.size() != 0));
    if (fifo_q.size() != 0) begin
      chk("out_id", 64'(bus.out_id), 64'(fifo_q[0].id));
      chkd("out_data", bus.out_data, fifo_q[0].data);
    end
    chk("fifo_count", 64'(bus.fifo_count), 64'(fifo_q.size()));
    chk("issue_err", 64'(bus.issue_err), 64'(m_err));
  endfunction

  function automatic void model_edge(bit v, logic [IW-1:0] id, bit rdy, logic [DW-1:0] dat);
    bit can_issue = (m_credits() != 0);
    if (fifo_q.size() != 0 && rdy) void'(fifo_q.pop_front());
    if (infl_q.size() != 0 && infl_q[0].due == cyc) begin
      fifo_q.push_back('{id: infl_q[0].id, data: dat});
      void'(infl_q.pop_front());
    end
    if (v) begin
      if (can_issue) infl_q.push_back('{id: id, due: cyc + LAT});
      else m_err = 1'b1;
    end
    cyc++;
  endfunction

  // Called at posedge+1; inputs held across the next edge.
  task automatic cycle(input bit v, input logic [IW-1:0] id, input bit rdy,
                       input logic [DW-1:0] dat);
    bus.rd_issue_valid = v;
    bus.rd_issue_id    = id;
    bus.out_ready      = rdy;
    bus.l3_rd_data_q   = dat;
    #4;
    model_check();
    if (bus.out_valid && rdy) popped_q.push_back(bus.out_id);
    @(posedge clk);
    model_edge(v, id, rdy, dat);
    #1;
  endtask

  task automatic check_reset_vals(string tag);
    chk({tag, "_ready"}, 64'(bus.rd_issue_ready), 64'd1);
    chk({tag, "_valid"}, 64'(bus.out_valid), 64'd0);
    chk({tag, "_count"}, 64'(bus.fifo_count), 64'd0);
    chk({tag, "_err"}, 64'(bus.issue_err), 64'd0);
    chk({tag, "_id"}, 64'(bus.out_id), 64'd0);
    chkd({tag, "_data"}, bus.out_data, '0);
  endtask

  // Reset is asserted and released between clock edges, and released before
  // an in-flight read would have returned.
  task automatic do_reset();
    bus.rd_issue_valid = 1'b0;
    bus.out_ready      = 1'b0;
    #1 rst = 1'b0;
    #1 check_reset_vals("async_rst");
    #1 rst = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    bit v; logic [IW-1:0] id; bit rdy; logic [7:0] dbyte;
    bit e_ready; bit e_valid; logic [IW-1:0] e_id; logic [7:0] e_dbyte;
    int e_cnt; bit e_err;
  } vec_t;
  vec_t vecs[13];

  function automatic vec_t mk(bit v, logic [7:0] id, bit rdy, logic [7:0] d, bit er,
                              bit ev, logic [7:0] eid, logic [7:0] ed, int ec, bit ee);
    vec_t r;
    r.v = v; r.id = id; r.rdy = rdy; r.dbyte = d;
    r.e_ready = er; r.e_valid = ev; r.e_id = eid; r.e_dbyte = ed;
    r.e_cnt = ec; r.e_err = ee;
    return r;
  endfunction

  initial begin
    int next_id;
    int stalls;
    bus.rd_issue_valid = 1'b0;
    bus.rd_issue_id    = '0;
    bus.out_ready      = 1'b0;
    bus.l3_rd_data_q   = '0;
    model_reset();

    // Credit exhaustion, illegal issue at zero credit, in-order drain.
    vecs[0]  = mk(1'b1, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 8'h00, 0, 1'b0);
    vecs[1]  = mk(1'b1, 8'h02, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 8'h00, 0, 1'b0);
    vecs[2]  = mk(1'b1, 8'h03, 1'b0, 8'h11, 1'b1, 1'b0, 8'h00, 8'h00, 0, 1'b0);
    vecs[3]  = mk(1'b1, 8'h04, 1'b0, 8'h22, 1'b1, 1'b1, 8'h01, 8'h11, 1, 1'b0);
    vecs[4]  = mk(1'b1, 8'h07, 1'b0, 8'h33, 1'b0, 1'b1, 8'h01, 8'h11, 2, 1'b0);
    vecs[5]  = mk(1'b0, 8'h00, 1'b0, 8'h44, 1'b0, 1'b1, 8'h01, 8'h11, 3, 1'b1);
    vecs[6]  = mk(1'b0, 8'h00, 1'b0, 8'h99, 1'b0, 1'b1, 8'h01, 8'h11, 4, 1'b1);
    vecs[7]  = mk(1'b0, 8'h00, 1'b1, 8'h99, 1'b0, 1'b1, 8'h01, 8'h11, 4, 1'b1);
    vecs[8]  = mk(1'b1, 8'h08, 1'b1, 8'h99, 1'b1, 1'b1, 8'h02, 8'h22, 3, 1'b1);
    vecs[9]  = mk(1'b0, 8'h00, 1'b1, 8'h99, 1'b1, 1'b1, 8'h03, 8'h33, 2, 1'b1);
    vecs[10] = mk(1'b0, 8'h00, 1'b1, 8'h88, 1'b1, 1'b1, 8'h04, 8'h44, 1, 1'b1);
    vecs[11] = mk(1'b0, 8'h00, 1'b1, 8'h99, 1'b1, 1'b1, 8'h08, 8'h88, 1, 1'b1);
    vecs[12] = mk(1'b0, 8'h00, 1'b0, 8'h99, 1'b1, 1'b0, 8'h00, 8'h00, 0, 1'b1);

    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    check_reset_vals("post_rst");

    for (int i = 0; i < 13; i++) begin
      bus.rd_issue_valid = vecs[i].v;
      bus.rd_issue_id    = vecs[i].id;
      bus.out_ready      = vecs[i].rdy;
      bus.l3_rd_data_q   = {64{vecs[i].dbyte}};
      #4;
      chk($sformatf("vec%0d_ready", i), 64'(bus.rd_issue_ready), 64'(vecs[i].e_ready));
      chk($sformatf("vec%0d_valid", i), 64'(bus.out_valid), 64'(vecs[i].e_valid));
      chk($sformatf("vec%0d_count", i), 64'(bus.fifo_count), 64'(vecs[i].e_cnt));
      chk($sformatf("vec%0d_err", i), 64'(bus.issue_err), 64'(vecs[i].e_err));
      if (vecs[i].e_valid) begin
        chk($sformatf("vec%0d_id", i), 64'(bus.out_id), 64'(vecs[i].e_id));
        chkd($sformatf("vec%0d_data", i), bus.out_data, {64{vecs[i].e_dbyte}});
      end
      @(posedge clk);
      #1;
    end

    // Single read latency.
    do_reset();
    cycle(1'b0, 8'h00, 1'b0, rl());
    cycle(1'b1, 8'h05, 1'b0, rl());
    cycle(1'b0, 8'h00, 1'b0, rl());
    cycle(1'b0, 8'h00, 1'b0, {64{8'hA5}});
    chk("lat_valid", 64'(bus.out_valid), 64'd1);
    chk("lat_id", 64'(bus.out_id), 64'h05);
    chkd("lat_data", bus.out_data, {64{8'hA5}});
    cycle(1'b0, 8'h00, 1'b1, rl());
    chk("lat_count_after_pop", 64'(bus.fifo_count), 64'd0);

    // Full-throughput streaming of ids 0..15.
    popped_q.delete();
    next_id = 0;
    stalls  = 0;
    for (int t = 0; t < 60 && popped_q.size() < 16; t++) begin
      if (next_id < 16 && !bus.rd_issue_ready) stalls++;
      if (next_id < 16 && m_credits() != 0) begin
        cycle(1'b1, 8'(next_id), 1'b1, rl());
        next_id++;
      end else begin
        cycle(1'b0, 8'h00, 1'b1, rl());
      end
    end
    chk("stream_pops", 64'(popped_q.size()), 64'd16);
    chk("stream_stalls", 64'(stalls), 64'd0);
    for (int i = 0; i < popped_q.size(); i++)
      chk($sformatf("stream_order%0d", i), 64'(popped_q[i]), 64'(i));

    // Backpressure stability and push+pop in the same cycle.
    do_reset();
    cycle(1'b1, 8'h30, 1'b0, rl());
    cycle(1'b1, 8'h31, 1'b0, rl());
    cycle(1'b1, 8'h32, 1'b0, {64{8'hC0}});
    cycle(1'b1, 8'h33, 1'b0, {64{8'hC1}});
    cycle(1'b0, 8'h00, 1'b0, {64{8'hC2}});
    cycle(1'b0, 8'h00, 1'b0, {64{8'hC3}});
    chk("bp_full_count", 64'(bus.fifo_count), 64'd4);
    chk("bp_full_ready", 64'(bus.rd_issue_ready), 64'd0);
    cycle(1'b0, 8'h00, 1'b1, rl());
    chk("bp_credit_back", 64'(bus.rd_issue_ready), 64'd1);
    chk("bp_head_id0", 64'(bus.out_id), 64'h31);
    cycle(1'b1, 8'h34, 1'b0, rl());
    chk("bp_hold_id1", 64'(bus.out_id), 64'h31);
    chkd("bp_hold_data1", bus.out_data, {64{8'hC1}});
    chk("bp_hold_count1", 64'(bus.fifo_count), 64'd3);
    cycle(1'b0, 8'h00, 1'b0, rl());
    chk("bp_hold_id2", 64'(bus.out_id), 64'h31);
    chkd("bp_hold_data2", bus.out_data, {64{8'hC1}});
    cycle(1'b0, 8'h00, 1'b1, {64{8'hC4}});
    chk("bp_pushpop_count", 64'(bus.fifo_count), 64'd3);
    chk("bp_pushpop_head", 64'(bus.out_id), 64'h32);
    repeat (6) cycle(1'b0, 8'h00, 1'b1, rl());
    chk("bp_drained", 64'(bus.fifo_count), 64'd0);

    // Reset with reads in flight: no stale push afterwards.
    cycle(1'b1, 8'h50, 1'b0, rl());
    cycle(1'b1, 8'h51, 1'b0, rl());
    do_reset();
    for (int i = 0; i < 5; i++) begin
      cycle(1'b0, 8'h00, 1'b1, {64{8'hEE}});
      chk($sformatf("stale_count%0d", i), 64'(bus.fifo_count), 64'd0);
      chk($sformatf("stale_valid%0d", i), 64'(bus.out_valid), 64'd0);
    end

    // Random traffic, including issues attempted without credit.
    for (int t = 0; t < 400; t++) begin
      cycle(($urandom_range(0, 9) < 6), 8'($urandom()), ($urandom_range(0, 9) < 6), rl());
    end
    repeat (8) cycle(1'b0, 8'h00, 1'b1, rl());

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
